// File: rtl/guess_entry.sv
// Digit-entry front end for a guessing game: synchronizes three buttons, builds a
// 1..3 digit BCD guess and strobes it out on confirm. Optional debounce: GUESS_ENTRY_DEBOUNCE_EN.
module guess_entry #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_sw,
  input  logic       enter_btn,
  input  logic       confirm_btn,
  input  logic       clear_btn,
  input  logic [1:0] required_digits,
  output logic [3:0] key0,
  output logic [3:0] key1,
  output logic [3:0] key2,
  output logic [1:0] entered_count,
  output logic       confirm_pulse,
  output logic       entry_error,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {IDLE, ENTRY, READY, SUBMIT} state_t;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  // Button vectors are ordered {clear, confirm, enter}.
  logic [2:0] btn_raw, s1, s2, level, prev, armed, rise;
  logic [1:0] settle;
  logic       settled;

  assign btn_raw = {clear_btn, confirm_btn, enter_btn};
  assign settled = (settle == 2'd2);
  // A button only arms once the synchronizer has seen it low after reset,
  // so a press held across reset never produces an action.
  assign rise    = level & ~prev & armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      prev   <= '0;
      armed  <= '0;
      settle <= '0;
    end else begin
      s1    <= btn_raw;
      s2    <= s1;
      prev  <= level;
      armed <= armed | (~s2 & {3{settled}});
      if (!settled) settle <= settle + 2'd1;
    end
  end

`ifdef GUESS_ENTRY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] db_cnt [3];
  logic [2:0]    db_level;

  assign level = db_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2[i] != db_level[i]) begin
          if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_level[i] <= s2[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign level = s2;
`endif

  state_t     state, state_nx;
  logic [3:0] k0_nx, k1_nx, k2_nx;
  logic [1:0] cnt_nx, req_eff, req_q;
  logic       cp_nx, err_nx, req_chg;

  assign req_eff   = (required_digits == 2'd0) ? 2'd1 : required_digits;
  assign req_chg   = (req_q != required_digits);
  assign fsm_state = state;

  always_comb begin
    state_nx = state;
    k0_nx    = key0;
    k1_nx    = key1;
    k2_nx    = key2;
    cnt_nx   = entered_count;
    cp_nx    = 1'b0;
    err_nx   = 1'b0;
    if (state == SUBMIT) begin
      state_nx = IDLE;
      {k2_nx, k1_nx, k0_nx} = '0;
      cnt_nx   = '0;
    end else if (rise[2] || req_chg) begin
      state_nx = IDLE;
      {k2_nx, k1_nx, k0_nx} = '0;
      cnt_nx   = '0;
    end else if (rise[1]) begin
      if (state == READY) begin
        state_nx = SUBMIT;
        cp_nx    = 1'b1;
      end else begin
        err_nx = 1'b1;
      end
    end else if (rise[0]) begin
      if (state != READY && digit_sw <= 4'd9) begin
        k2_nx    = key1;
        k1_nx    = key0;
        k0_nx    = digit_sw;
        cnt_nx   = entered_count + 2'd1;
        state_nx = (cnt_nx == req_eff) ? READY : ENTRY;
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      key0          <= '0;
      key1          <= '0;
      key2          <= '0;
      entered_count <= '0;
      confirm_pulse <= 1'b0;
      entry_error   <= 1'b0;
      req_q         <= '0;
    end else begin
      state         <= state_nx;
      key0          <= k0_nx;
      key1          <= k1_nx;
      key2          <= k2_nx;
      entered_count <= cnt_nx;
      confirm_pulse <= cp_nx;
      entry_error   <= err_nx;
      req_q         <= required_digits;
    end
  end

endmodule

// File: tb/tb_guess_entry.sv
// Scoreboarded bench for guess_entry: directed cases plus random button traffic
// checked against a digit-list model of the guess.
module tb_guess_entry;

`ifdef GUESS_ENTRY_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int HOLD = 3 + DB;
  localparam int GAP  = 6 + DB;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] digit_sw;
  logic       enter_btn, confirm_btn, clear_btn;
  logic [1:0] required_digits;
  logic [3:0] key0, key1, key2;
  logic [1:0] entered_count;
  logic       confirm_pulse, entry_error;
  logic [1:0] fsm_state;

  guess_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .digit_sw(digit_sw), .enter_btn(enter_btn),
    .confirm_btn(confirm_btn), .clear_btn(clear_btn), .required_digits(required_digits),
    .key0(key0), .key1(key1), .key2(key2), .entered_count(entered_count),
    .confirm_pulse(confirm_pulse), .entry_error(entry_error), .fsm_state(fsm_state)
  );

  int total = 0;
  int bad   = 0;

  // Event word: {confirm, error, key2, key1, key0, count}
  logic [15:0] exp_q[$];

  // Reference model: the guess is a list of digits, oldest first.
  int digs[$];
  int req_v;

  function automatic int req_eff();
    return (req_v == 0) ? 1 : req_v;
  endfunction

  function automatic logic [11:0] model_keys();
    logic [11:0] k = '0;
    for (int i = 0; i < 3; i++)
      if (i < digs.size()) k[i*4 +: 4] = 4'(digs[digs.size() - 1 - i]);
    return k;
  endfunction

  function automatic int model_state();
    if (digs.size() == 0) return 0;
    if (digs.size() == req_eff()) return 2;
    return 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (confirm_pulse || entry_error) begin
      logic [15:0] act;
      act = {confirm_pulse, entry_error, key2, key1, key0, entered_count};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event actual=%h required=none", act);
      end else begin
        check("event", int'(act), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_error();
    exp_q.push_back({2'b01, model_keys(), 2'(digs.size())});
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    @(negedge clk);
    {clear_btn, confirm_btn, enter_btn} = m;
    repeat (hold) @(negedge clk);
    {clear_btn, confirm_btn, enter_btn} = 3'b000;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic check_state(input string name);
    check({name, "_keys"}, int'({key2, key1, key0}), int'(model_keys()));
    check({name, "_count"}, int'(entered_count), digs.size());
    check({name, "_state"}, int'(fsm_state), model_state());
  endtask

  // driver tasks: model update first, then the button press
  task automatic do_enter(input int d, input int hold);
    @(negedge clk);
    digit_sw = 4'(d);
    if (digs.size() < req_eff() && d <= 9) digs.push_back(d);
    else push_error();
    press(3'b001, hold);
  endtask

  task automatic do_confirm(input int hold);
    if (digs.size() == req_eff()) begin
      exp_q.push_back({2'b10, model_keys(), 2'(digs.size())});
      digs.delete();
    end else begin
      push_error();
    end
    press(3'b010, hold);
  endtask

  task automatic do_clear(input int hold);
    digs.delete();
    press(3'b100, hold);
  endtask

  task automatic set_req(input int v);
    @(negedge clk);
    required_digits = 2'(v);
    if (v != req_v) digs.delete();
    req_v = v;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    {clear_btn, confirm_btn, enter_btn} = 3'b000;
    digit_sw = 4'd0;
    required_digits = 2'd3;
    req_v = 3;
    #1;
    check("reset_keys", int'({key2, key1, key0}), 0);
    check("reset_count", int'(entered_count), 0);
    check("reset_strobes", int'({confirm_pulse, entry_error}), 0);
    check("reset_state", int'(fsm_state), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // three-digit guess submitted
    do_enter(4, HOLD); do_enter(0, HOLD); do_enter(7, HOLD);
    check_state("ready3");
    do_confirm(HOLD);
    check_state("after_submit");

    // confirm too early
    set_req(2);
    do_enter(5, HOLD);
    do_confirm(HOLD);
    check_state("early_confirm");

    // invalid digit
    do_enter(12, HOLD);
    check_state("bad_digit");
    do_clear(HOLD);

    // enter while already full
    set_req(1);
    do_enter(3, HOLD);
    do_enter(6, HOLD);
    check_state("full_enter");

    // clear and confirm together in READY
    set_req(2);
    do_enter(1, HOLD); do_enter(2, HOLD);
    digs.delete();
    press(3'b110, HOLD);
    check_state("clear_beats_confirm");

    // required_digits of 0 acts as 1, long hold gives one action
    set_req(0);
    do_enter(9, HOLD + 20);
    check_state("req0_long_hold");
    do_confirm(HOLD);

    // required_digits change drops partial entry
    set_req(3);
    do_enter(8, HOLD);
    set_req(2);
    check_state("req_change");

`ifdef GUESS_ENTRY_DEBOUNCE_EN
    @(negedge clk);
    digit_sw = 4'd6;
    press(3'b001, 3);
    check_state("glitch");
    do_enter(6, 10);
    check_state("debounced_press");
    do_clear(HOLD);
`endif

    // reset in the middle of a held press
    do_enter(2, HOLD);
    @(negedge clk);
    enter_btn = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    digs.delete();
    check("async_reset_count", int'(entered_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10 + DB) @(negedge clk);
    enter_btn = 1'b0;
    repeat (GAP) @(negedge clk);
    check_state("reset_mid_press");

    // random traffic
    for (int n = 0; n < 150; n++) begin
      int op;
      int h;
      op = $urandom_range(0, 9);
      h  = $urandom_range(HOLD, HOLD + 5);
      if (op <= 5)      do_enter($urandom_range(0, 11), h);
      else if (op <= 7) do_confirm(h);
      else if (op == 8) do_clear(h);
      else              set_req($urandom_range(0, 3));
      check_state("random");
    end

    repeat (5) @(negedge clk);
    check("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/guess_entry.md
GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning stable-sample count needed to accept a button level change when debounce is compiled in.
REQ-002 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port digit_sw, input, 4 bits: BCD digit to append (0..9 valid).
REQ-005 SHALL have port enter_btn, input, 1 bit: raw, asynchronous button that appends digit_sw.
REQ-006 SHALL have port confirm_btn, input, 1 bit: raw, asynchronous button that submits the guess.
REQ-007 SHALL have port clear_btn, input, 1 bit: raw, asynchronous button that discards the partial guess.
REQ-008 SHALL have port required_digits, input, 2 bits: guess length (1..3); 0 is treated as 1.
REQ-009 SHALL have ports key0, key1, key2, outputs, 4 bits each: entered digits; key0 is the least significant and most recent.
REQ-010 SHALL have port entered_count, output, 2 bits: number of digits currently held.
REQ-011 SHALL have port confirm_pulse, output, 1 bit: one-cycle submit strobe to the hint/compare stage.
REQ-012 SHALL have port entry_error, output, 1 bit: one-cycle strobe on a rejected action.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a rising-edge detector; only edges act.
REQ-014 Without DEBOUNCE_EN, an input first sampled high at edge N SHALL take effect at edge N+2.
REQ-015 The FSM SHALL have states IDLE (count 0), ENTRY (0 < count < req), READY (count = req) and SUBMIT.
REQ-016 On an accepted enter, the block SHALL shift key2<=key1, key1<=key0, key0<=digit_sw and increment entered_count.
REQ-017 Enter SHALL be accepted only in IDLE or ENTRY with digit_sw <= 9.
REQ-018 Enter with digit_sw > 9, or enter in READY, SHALL leave keys and count unchanged and pulse entry_error.
REQ-019 Confirm in READY SHALL move to SUBMIT and assert confirm_pulse for exactly one cycle.
REQ-020 While confirm_pulse is high, key0..key2 SHALL hold stable.
REQ-021 Confirm in IDLE or ENTRY SHALL pulse entry_error and leave state unchanged.
REQ-022 SUBMIT SHALL last one cycle, then clear keys to 0 and count to 0, and return to IDLE.
REQ-023 Clear SHALL return to IDLE with keys and count at 0 from any state except SUBMIT, where it is ignored.
REQ-024 When edges coincide in one cycle, priority SHALL be clear > confirm > enter, and lower-priority edges are dropped with no error.
REQ-025 A change of required_digits (compared against a registered copy) SHALL clear the entry to IDLE in the next cycle, unless the FSM is in SUBMIT.
REQ-026 entered_count SHALL never exceed the effective required_digits.
REQ-027 Buttons held high SHALL produce only one action per press.

Reset
REQ-028 Asserting rst_n low SHALL immediately force key0..key2=0, entered_count=0, confirm_pulse=0, entry_error=0, FSM=IDLE, and clear synchronizers, debounce counters and edge registers.
REQ-029 Reset mid-press SHALL NOT generate an action after release of reset while the button stays high.

Configuration
REQ-030 With macro GUESS_ENTRY_DEBOUNCE_EN defined, each synchronized button SHALL change its debounced level only after DEBOUNCE_CYCLES consecutive equal samples, giving an effect at edge N+2+DEBOUNCE_CYCLES.
REQ-031 With the macro undefined, no debounce counters SHALL exist and REQ-014 timing applies.

Verification
REQ-032 The bench SHALL cover: required_digits=3, enter 4, 0, 7, then confirm -> key2=4, key1=0, key0=7, confirm_pulse high 1 cycle, then all keys 0 and count 0.
REQ-033 The bench SHALL cover: required_digits=2, enter 5, then confirm -> entry_error pulse, no confirm_pulse, count stays 1.
REQ-034 The bench SHALL cover: digit_sw=12 with enter -> entry_error, keys unchanged.
REQ-035 The bench SHALL cover: required_digits=1, enter 3, then a second enter of 6 -> entry_error, key0 stays 3.
REQ-036 The bench SHALL cover: clear and confirm edges in the same cycle while in READY -> IDLE with no confirm_pulse.
REQ-037 The bench SHALL cover: with GUESS_ENTRY_DEBOUNCE_EN and DEBOUNCE_CYCLES=4, a 3-cycle enter glitch -> no action; a 10-cycle press -> exactly one digit appended.
